// File: rtl/ccu_snoop_sched_pkg.sv
// Shared ACE snoop encodings, CRRESP bit positions and scheduler state type.
package ccu_snoop_sched_pkg;

  localparam int CrDataTransfer = 0;
  localparam int CrError        = 1;
  localparam int CrPassDirty    = 2;
  localparam int CrIsShared     = 3;
  localparam int CrWasUnique    = 4;

  localparam logic [3:0] ArReadOnce     = 4'b0000;
  localparam logic [3:0] ArReadShared   = 4'b0001;
  localparam logic [3:0] ArReadClean    = 4'b0010;
  localparam logic [3:0] ArReadUnique   = 4'b0111;

  localparam logic [2:0] AwWriteUnique     = 3'b000;
  localparam logic [2:0] AwWriteLineUnique = 3'b001;

  localparam logic [3:0] AcCleanInvalid = 4'b1001;
  localparam logic [3:0] AcMakeInvalid  = 4'b1101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSnoop  = 2'd1,
    StResult = 2'd2
  } ccu_snoop_state_e;

  // A partial-line WriteUnique must push dirty data home first; full-line writes just invalidate.
  function automatic logic [3:0] aw_to_ac(input logic [2:0] aw_snoop);
    return (aw_snoop == AwWriteUnique) ? AcCleanInvalid : AcMakeInvalid;
  endfunction

endpackage

// File: rtl/ccu_snoop_sched_if.sv
// AR/AW request, AC/CR snoop and aggregated-result bundle around the snoop scheduler.
interface ccu_snoop_sched_if #(
  parameter int NoPorts   = 4,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
);
  logic                 ar_valid_i;
  logic                 ar_ready_o;
  logic [AddrWidth-1:0] ar_addr_i;
  logic [3:0]           ar_snoop_i;
  logic [IdxWidth-1:0]  ar_src_i;
  logic                 aw_valid_i;
  logic                 aw_ready_o;
  logic [AddrWidth-1:0] aw_addr_i;
  logic [2:0]           aw_snoop_i;
  logic [IdxWidth-1:0]  aw_src_i;
  logic [NoPorts-1:0]   ac_valid_o;
  logic [NoPorts-1:0]   ac_ready_i;
  logic [AddrWidth-1:0] ac_addr_o;
  logic [3:0]           ac_snoop_o;
  logic [NoPorts-1:0]   cr_valid_i;
  logic [NoPorts-1:0]   cr_ready_o;
  logic [5*NoPorts-1:0] cr_resp_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic                 res_write_o;
  logic [IdxWidth-1:0]  res_src_o;
  logic [4:0]           res_resp_o;
  logic [NoPorts-1:0]   res_data_mask_o;

  modport slave (
    input  ar_valid_i, ar_addr_i, ar_snoop_i, ar_src_i,
    input  aw_valid_i, aw_addr_i, aw_snoop_i, aw_src_i,
    input  ac_ready_i, cr_valid_i, cr_resp_i, res_ready_i,
    output ar_ready_o, aw_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, cr_ready_o,
    output res_valid_o, res_write_o, res_src_o, res_resp_o, res_data_mask_o
  );

  modport master (
    output ar_valid_i, ar_addr_i, ar_snoop_i, ar_src_i,
    output aw_valid_i, aw_addr_i, aw_snoop_i, aw_src_i,
    output ac_ready_i, cr_valid_i, cr_resp_i, res_ready_i,
    input  ar_ready_o, aw_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, cr_ready_o,
    input  res_valid_o, res_write_o, res_src_o, res_resp_o, res_data_mask_o
  );
endinterface

// File: rtl/ccu_snoop_sched_port_track.sv
// Per-port snoop progress: AC handshake first, then exactly one CR is accepted from that port.
module ccu_snoop_port_track (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic active,
  input  logic target,
  input  logic ac_ready,
  input  logic cr_valid,
  output logic ac_valid,
  output logic cr_ready,
  output logic cr_done,
  output logic cr_fire
);
  logic ac_done;
  logic cr_done_q;

  // cr_ready only opens once ac_done is registered, so a CR racing the AC waits a cycle.
  assign ac_valid = active & target & ~ac_done;
  assign cr_ready = active & target & ac_done & ~cr_done_q;
  assign cr_fire  = cr_ready & cr_valid;
  assign cr_done  = cr_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      ac_done   <= 1'b0;
      cr_done_q <= 1'b0;
    end else begin
      if (ac_valid && ac_ready) ac_done <= 1'b1;
      if (cr_fire) cr_done_q <= 1'b1;
    end
  end
endmodule

// File: rtl/ccu_snoop_sched.sv
// Snoop scheduler: arbitrates shareable AR/AW, broadcasts AC to all other ports, aggregates CR.
module ccu_snoop_sched
  import ccu_snoop_sched_pkg::*;
#(
  parameter int NoPorts   = 4,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input logic               clk_i,
  input logic               rst_i,
  ccu_snoop_sched_if.slave  bus
);
  ccu_snoop_state_e state, state_nxt;

  logic                 last_aw;
  logic                 sel_ar, sel_aw, grant;
  logic [IdxWidth-1:0]  grant_src;
  logic [NoPorts-1:0]   target_nxt;
  logic                 in_snoop, in_result, all_done;

  logic                 op_write;
  logic [AddrWidth-1:0] addr;
  logic [IdxWidth-1:0]  src;
  logic [3:0]           snoop;
  logic [NoPorts-1:0]   target;
  logic [4:0]           resp;
  logic [NoPorts-1:0]   mask;

  logic [NoPorts-1:0]   ac_valid, cr_ready, cr_done, cr_fire;
  logic [4:0]           cr_or;
  logic [NoPorts-1:0]   cr_dt;

  assign in_snoop  = (state == StSnoop);
  assign in_result = (state == StResult);

  // Round-robin between the two channels; last_aw resets high so AR wins the first tie.
  assign sel_ar    = bus.ar_valid_i & (~bus.aw_valid_i | last_aw);
  assign sel_aw    = bus.aw_valid_i & (~bus.ar_valid_i | ~last_aw);
  assign grant_src = sel_ar ? bus.ar_src_i : bus.aw_src_i;

  always_comb begin
    target_nxt = '0;
    for (int i = 0; i < NoPorts; i++) target_nxt[i] = (IdxWidth'(i) != grant_src);
  end

  always_comb begin
    cr_or = '0;
    cr_dt = '0;
    for (int i = 0; i < NoPorts; i++) begin
      if (cr_fire[i]) begin
        cr_or    = cr_or | bus.cr_resp_i[5*i +: 5];
        cr_dt[i] = bus.cr_resp_i[5*i + CrDataTransfer];
      end
    end
  end

  assign all_done = ((cr_done | cr_fire) == target);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= StIdle;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    grant           = 1'b0;
    bus.ar_ready_o  = 1'b0;
    bus.aw_ready_o  = 1'b0;
    unique case (state)
      StIdle: begin
        if (!rst_i && (sel_ar || sel_aw)) begin
          grant          = 1'b1;
          bus.ar_ready_o = sel_ar;
          bus.aw_ready_o = sel_aw;
          state_nxt      = (target_nxt == '0) ? StResult : StSnoop;
        end
      end
      StSnoop:  if (all_done) state_nxt = StResult;
      StResult: if (bus.res_ready_i) state_nxt = StIdle;
      default:  state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      last_aw <= 1'b1;
    else if (grant) last_aw <= sel_aw;
  end

  // Transaction context; outputs are gated by state, so these need no reset.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      op_write <= sel_aw;
      addr     <= sel_ar ? bus.ar_addr_i : bus.aw_addr_i;
      src      <= grant_src;
      snoop    <= sel_ar ? bus.ar_snoop_i : aw_to_ac(bus.aw_snoop_i);
      target   <= target_nxt;
      resp     <= '0;
      mask     <= '0;
    end else if (in_snoop) begin
      resp     <= resp | cr_or;
      mask     <= mask | cr_dt;
    end
  end

  for (genvar i = 0; i < NoPorts; i++) begin : g_port
    ccu_snoop_port_track u_track (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear    (grant),
      .active   (in_snoop),
      .target   (target[i]),
      .ac_ready (bus.ac_ready_i[i]),
      .cr_valid (bus.cr_valid_i[i]),
      .ac_valid (ac_valid[i]),
      .cr_ready (cr_ready[i]),
      .cr_done  (cr_done[i]),
      .cr_fire  (cr_fire[i])
    );
  end

  assign bus.ac_valid_o      = ac_valid;
  assign bus.cr_ready_o      = cr_ready;
  assign bus.ac_addr_o       = in_snoop ? addr : '0;
  assign bus.ac_snoop_o      = in_snoop ? snoop : '0;
  assign bus.res_valid_o     = in_result;
  assign bus.res_write_o     = in_result & op_write;
  assign bus.res_src_o       = in_result ? src : '0;
  assign bus.res_resp_o      = in_result ? resp : '0;
  assign bus.res_data_mask_o = in_result ? mask : '0;

  a_ac_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (|bus.ac_valid_o) |=> $stable(bus.ac_addr_o) && $stable(bus.ac_snoop_o));
  a_res_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.res_valid_o && !bus.res_ready_i) |=> bus.res_valid_o &&
      $stable({bus.res_write_o, bus.res_src_o, bus.res_resp_o, bus.res_data_mask_o}));
  a_src_range: assert property (@(posedge clk_i) disable iff (rst_i)
    grant |-> (int'(grant_src) < NoPorts));
endmodule

// File: tb/tb_ccu_snoop_sched.sv
// Directed bench for the snoop scheduler: a 4-port instance plus a 1-port instance.
module tb_ccu_snoop_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ccu_snoop_sched_if #(.NoPorts(4), .AddrWidth(64), .IdxWidth(2)) if4 ();
  ccu_snoop_sched_if #(.NoPorts(1), .AddrWidth(64), .IdxWidth(1)) if1 ();

  ccu_snoop_sched #(.NoPorts(4), .AddrWidth(64), .IdxWidth(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .bus(if4.slave));
  ccu_snoop_sched #(.NoPorts(1), .AddrWidth(64), .IdxWidth(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res4(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (if4.res_valid_o) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic init_inputs();
    if4.ar_valid_i = 0; if4.ar_addr_i = '0; if4.ar_snoop_i = '0; if4.ar_src_i = '0;
    if4.aw_valid_i = 0; if4.aw_addr_i = '0; if4.aw_snoop_i = '0; if4.aw_src_i = '0;
    if4.ac_ready_i = 4'b1111; if4.cr_valid_i = 4'b1111; if4.cr_resp_i = '0; if4.res_ready_i = 0;
    if1.ar_valid_i = 0; if1.ar_addr_i = '0; if1.ar_snoop_i = '0; if1.ar_src_i = '0;
    if1.aw_valid_i = 0; if1.aw_addr_i = '0; if1.aw_snoop_i = '0; if1.aw_src_i = '0;
    if1.ac_ready_i = 1'b1; if1.cr_valid_i = 1'b0; if1.cr_resp_i = '0; if1.res_ready_i = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.ar_valid_i = 1; if4.aw_valid_i = 1; if1.aw_valid_i = 1;
    tick(); tick();
    n_tests++; if ({if4.ar_ready_o, if4.aw_ready_o} !== 2'b00) begin n_fail++;
      $display("FAIL rst_ready: got %b want 00", {if4.ar_ready_o, if4.aw_ready_o}); end
    n_tests++; if ({if4.ac_valid_o, if4.cr_ready_o} !== 8'h00) begin n_fail++;
      $display("FAIL rst_ac_cr: got %b want 0", {if4.ac_valid_o, if4.cr_ready_o}); end
    n_tests++; if ({if4.res_valid_o, if4.res_resp_o, if4.ac_snoop_o, if4.ac_addr_o} !== '0) begin n_fail++;
      $display("FAIL rst_res: got valid=%b resp=%b want 0", if4.res_valid_o, if4.res_resp_o); end
    n_tests++; if ({if1.res_valid_o, if1.aw_ready_o} !== 2'b00) begin n_fail++;
      $display("FAIL rst_p1: got %b want 00", {if1.res_valid_o, if1.aw_ready_o}); end
    if4.ar_valid_i = 0; if4.aw_valid_i = 0; if1.aw_valid_i = 0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    if4.ar_valid_i = 1; if4.ar_addr_i = 64'h1000; if4.ar_snoop_i = 4'b0001; if4.ar_src_i = 2'd1;
    if4.cr_resp_i = '0; #1;
    n_tests++; if ({if4.ar_ready_o, if4.aw_ready_o} !== 2'b10) begin n_fail++;
      $display("FAIL rd_grant: got %b want 10", {if4.ar_ready_o, if4.aw_ready_o}); end
    tick(); if4.ar_valid_i = 0;
    n_tests++; if (if4.ac_valid_o !== 4'b1101) begin n_fail++;
      $display("FAIL rd_ac_valid: got %b want 1101", if4.ac_valid_o); end
    n_tests++; if (if4.ac_addr_o !== 64'h1000 || if4.ac_snoop_o !== 4'b0001) begin n_fail++;
      $display("FAIL rd_ac_payload: got %h/%b want 1000/0001", if4.ac_addr_o, if4.ac_snoop_o); end
    n_tests++; if (if4.cr_ready_o !== 4'b0000) begin n_fail++;
      $display("FAIL rd_cr_early: got %b want 0000", if4.cr_ready_o); end
    tick();
    n_tests++; if ({if4.ac_valid_o, if4.cr_ready_o} !== 8'b0000_1101) begin n_fail++;
      $display("FAIL rd_cr_ready: got %b want 00001101", {if4.ac_valid_o, if4.cr_ready_o}); end
    tick();
    n_tests++; if ({if4.res_valid_o, if4.res_write_o, if4.res_src_o, if4.res_resp_o, if4.res_data_mask_o}
                   !== {1'b1, 1'b0, 2'd1, 5'b00000, 4'b0000}) begin n_fail++;
      $display("FAIL rd_res: got v=%b w=%b src=%0d resp=%b mask=%b want 1 0 1 00000 0000",
               if4.res_valid_o, if4.res_write_o, if4.res_src_o, if4.res_resp_o, if4.res_data_mask_o); end
    if4.res_ready_i = 1; tick(); if4.res_ready_i = 0;
    n_tests++; if (if4.res_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL rd_res_drop: got %b want 0", if4.res_valid_o); end
  endtask

  task automatic test_read_resp();
    bit ok;
    if4.cr_resp_i = '0; if4.cr_resp_i[10 +: 5] = 5'b01101;
    if4.ar_valid_i = 1; if4.ar_addr_i = 64'h1100; if4.ar_src_i = 2'd1; #1;
    n_tests++; if (if4.ar_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL rsp_grant: got %b want 1", if4.ar_ready_o); end
    tick(); if4.ar_valid_i = 0;
    wait_res4(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rsp_timeout: got no res_valid want 1"); end
    n_tests++; if ({if4.res_resp_o, if4.res_data_mask_o, if4.res_write_o} !== {5'b01101, 4'b0100, 1'b0}) begin
      n_fail++; $display("FAIL rsp_agg: got resp=%b mask=%b w=%b want 01101 0100 0",
                         if4.res_resp_o, if4.res_data_mask_o, if4.res_write_o); end
    if4.res_ready_i = 1; tick(); if4.res_ready_i = 0;
    if4.cr_resp_i = '0;
  endtask

  task automatic test_arbitration();
    bit ok; bit exp_aw; logic [3:0] exp_snoop;
    rst = 1; tick(); tick(); rst = 0; tick();
    if4.ar_addr_i = 64'hA000; if4.ar_snoop_i = 4'b0010; if4.ar_src_i = 2'd0;
    if4.aw_addr_i = 64'hB000; if4.aw_snoop_i = 3'b000;  if4.aw_src_i = 2'd3;
    if4.ar_valid_i = 1; if4.aw_valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      exp_aw = k[0];
      exp_snoop = !exp_aw ? 4'b0010 : ((k == 1) ? 4'b1001 : 4'b1101);
      #1;
      n_tests++; if ({if4.ar_ready_o, if4.aw_ready_o} !== {!exp_aw, exp_aw}) begin n_fail++;
        $display("FAIL arb_order%0d: got %b want %b", k, {if4.ar_ready_o, if4.aw_ready_o}, {!exp_aw, exp_aw}); end
      tick();
      n_tests++; if (if4.ac_snoop_o !== exp_snoop ||
                     if4.ac_addr_o !== (exp_aw ? 64'hB000 : 64'hA000) ||
                     if4.ac_valid_o !== (exp_aw ? 4'b0111 : 4'b1110)) begin n_fail++;
        $display("FAIL arb_ac%0d: got snoop=%b addr=%h v=%b want %b", k, if4.ac_snoop_o, if4.ac_addr_o,
                 if4.ac_valid_o, exp_snoop); end
      if (k == 1) if4.aw_snoop_i = 3'b001;
      wait_res4(ok);
      n_tests++; if (!ok || if4.res_write_o !== exp_aw || if4.res_src_o !== (exp_aw ? 2'd3 : 2'd0)) begin
        n_fail++; $display("FAIL arb_res%0d: got ok=%b w=%b src=%0d want w=%b", k, ok, if4.res_write_o,
                           if4.res_src_o, exp_aw); end
      if4.res_ready_i = 1; tick(); if4.res_ready_i = 0;
    end
    if4.ar_valid_i = 0; if4.aw_valid_i = 0;
    tick();
  endtask

  task automatic test_slow_port();
    if4.ac_ready_i = 4'b0111;
    if4.ar_valid_i = 1; if4.ar_addr_i = 64'h2000; if4.ar_snoop_i = 4'b0001; if4.ar_src_i = 2'd1; #1;
    tick(); if4.ar_valid_i = 0;
    n_tests++; if (if4.ac_valid_o !== 4'b1101) begin n_fail++;
      $display("FAIL slow_ac0: got %b want 1101", if4.ac_valid_o); end
    tick();
    n_tests++; if ({if4.ac_valid_o, if4.cr_ready_o} !== 8'b1000_0101) begin n_fail++;
      $display("FAIL slow_split: got %b want 10000101", {if4.ac_valid_o, if4.cr_ready_o}); end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (if4.ac_valid_o !== 4'b1000 || if4.ac_addr_o !== 64'h2000 || if4.res_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL slow_hold%0d: got v=%b addr=%h res=%b want 1000 2000 0", i,
                           if4.ac_valid_o, if4.ac_addr_o, if4.res_valid_o); end
      tick();
    end
    if4.ac_ready_i = 4'b1111;
    tick();
    n_tests++; if ({if4.ac_valid_o, if4.cr_ready_o, if4.res_valid_o} !== 9'b0000_1000_0) begin n_fail++;
      $display("FAIL slow_p3_cr: got %b want 000010000", {if4.ac_valid_o, if4.cr_ready_o, if4.res_valid_o}); end
    tick();
    n_tests++; if (if4.res_valid_o !== 1'b1) begin n_fail++;
      $display("FAIL slow_res: got %b want 1", if4.res_valid_o); end
    if4.res_ready_i = 1; tick(); if4.res_ready_i = 0;
  endtask

  task automatic test_res_stall();
    bit ok;
    if4.cr_resp_i = {5'b00100, 5'b00011, 5'b10000, 5'b01000};
    if4.ar_valid_i = 1; if4.ar_addr_i = 64'h4000; if4.ar_snoop_i = 4'b0001; if4.ar_src_i = 2'd0;
    if4.aw_src_i = 2'd3; if4.aw_snoop_i = 3'b000; #1;
    tick();
    if4.aw_valid_i = 1;
    wait_res4(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no res_valid want 1"); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if ({if4.res_valid_o, if4.res_write_o, if4.res_src_o, if4.res_resp_o, if4.res_data_mask_o,
                      if4.ar_ready_o, if4.aw_ready_o} !== {1'b1, 1'b0, 2'd0, 5'b10111, 4'b0100, 2'b00}) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b resp=%b mask=%b rdy=%b%b want 1 10111 0100 00", i,
                           if4.res_valid_o, if4.res_resp_o, if4.res_data_mask_o, if4.ar_ready_o, if4.aw_ready_o); end
      tick();
    end
    if4.res_ready_i = 1; #1;
    n_tests++; if ({if4.ar_ready_o, if4.aw_ready_o} !== 2'b00) begin n_fail++;
      $display("FAIL stall_overlap: got %b want 00", {if4.ar_ready_o, if4.aw_ready_o}); end
    tick(); if4.res_ready_i = 0;
    n_tests++; if ({if4.res_valid_o, if4.ar_ready_o, if4.aw_ready_o} !== 3'b001) begin n_fail++;
      $display("FAIL stall_next_grant: got %b want 001", {if4.res_valid_o, if4.ar_ready_o, if4.aw_ready_o}); end
    if4.ar_valid_i = 0; if4.aw_valid_i = 0; if4.cr_resp_i = '0;
    tick();
  endtask

  task automatic test_reset_snoop();
    bit ok;
    if4.ac_ready_i = 4'b0000;
    if4.ar_valid_i = 1; if4.ar_addr_i = 64'h5000; if4.ar_snoop_i = 4'b0001; if4.ar_src_i = 2'd2; #1;
    tick();
    n_tests++; if (if4.ac_valid_o !== 4'b1011) begin n_fail++;
      $display("FAIL rsn_ac: got %b want 1011", if4.ac_valid_o); end
    rst = 1; if4.ar_addr_i = 64'h3000; if4.ar_src_i = 2'd3;
    tick();
    n_tests++; if ({if4.ac_valid_o, if4.cr_ready_o, if4.res_valid_o, if4.ar_ready_o} !== '0 ||
                   if4.ac_addr_o !== 64'h0) begin n_fail++;
      $display("FAIL rsn_clear: got ac=%b cr=%b res=%b rdy=%b addr=%h want 0", if4.ac_valid_o,
               if4.cr_ready_o, if4.res_valid_o, if4.ar_ready_o, if4.ac_addr_o); end
    rst = 0; if4.ac_ready_i = 4'b1111; if4.cr_resp_i = '0; if4.cr_resp_i[0 +: 5] = 5'b00001; #1;
    n_tests++; if (if4.ar_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL rsn_regrant: got %b want 1", if4.ar_ready_o); end
    tick(); if4.ar_valid_i = 0;
    n_tests++; if (if4.ac_valid_o !== 4'b0111 || if4.ac_addr_o !== 64'h3000) begin n_fail++;
      $display("FAIL rsn_ac2: got %b/%h want 0111/3000", if4.ac_valid_o, if4.ac_addr_o); end
    wait_res4(ok);
    n_tests++; if (!ok || {if4.res_resp_o, if4.res_data_mask_o, if4.res_src_o} !== {5'b00001, 4'b0001, 2'd3}) begin
      n_fail++; $display("FAIL rsn_res: got ok=%b resp=%b mask=%b src=%0d want 00001 0001 3", ok,
                         if4.res_resp_o, if4.res_data_mask_o, if4.res_src_o); end
    if4.res_ready_i = 1; tick(); if4.res_ready_i = 0; if4.cr_resp_i = '0;
  endtask

  task automatic test_single_port();
    if1.aw_valid_i = 1; if1.aw_addr_i = 64'h40; if1.aw_snoop_i = 3'b000; if1.aw_src_i = 1'b0; #1;
    n_tests++; if (if1.aw_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL p1_grant: got %b want 1", if1.aw_ready_o); end
    tick(); if1.aw_valid_i = 0;
    n_tests++; if ({if1.res_valid_o, if1.res_write_o, if1.res_src_o, if1.res_resp_o, if1.ac_valid_o}
                   !== {1'b1, 1'b1, 1'b0, 5'b00000, 1'b0}) begin n_fail++;
      $display("FAIL p1_res: got v=%b w=%b resp=%b ac=%b want 1 1 00000 0", if1.res_valid_o,
               if1.res_write_o, if1.res_resp_o, if1.ac_valid_o); end
    if1.res_ready_i = 1; tick(); if1.res_ready_i = 0;
    n_tests++; if (if1.res_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL p1_drop: got %b want 0", if1.res_valid_o); end
  endtask

  initial begin
    rst = 1'b1;
    init_inputs();
    test_reset();
    test_read_basic();
    test_read_resp();
    test_arbitration();
    test_slow_port();
    test_res_stall();
    test_reset_snoop();
    test_single_port();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
